// File: rtl/axi_sample_bridge.sv
// rtl/axi_sample_bridge.sv - AXI4 slave bridge between the host bus and the FFT sample RAM.
// Writes load RAM samples; reads stream results through a latency-matched skid FIFO.
module axi_sample_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 1024,
   parameter int ID_WIDTH   = 2,
   parameter int RAM_RD_LAT = 1,
   localparam int IDX_W     = $clog2(DEPTH),
   localparam int STRB_W    = DATA_WIDTH / 8
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [ADDR_WIDTH-1:0] i_awaddr,
   input  logic [7:0]            i_awlen,
   input  logic [2:0]            i_awsize,
   input  logic [1:0]            i_awburst,
   input  logic [ID_WIDTH-1:0]   i_awid,
   input  logic                  i_awvalid,
   output logic                  o_awready,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [STRB_W-1:0]     i_wstrb,
   input  logic                  i_wlast,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   output logic [ID_WIDTH-1:0]   o_bid,
   output logic [1:0]            o_bresp,
   output logic                  o_bvalid,
   input  logic                  i_bready,
   input  logic [ADDR_WIDTH-1:0] i_araddr,
   input  logic [7:0]            i_arlen,
   input  logic [2:0]            i_arsize,
   input  logic [1:0]            i_arburst,
   input  logic [ID_WIDTH-1:0]   i_arid,
   input  logic                  i_arvalid,
   output logic                  o_arready,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic [ID_WIDTH-1:0]   o_rid,
   output logic [1:0]            o_rresp,
   output logic                  o_rlast,
   output logic                  o_rvalid,
   input  logic                  i_rready,
   output logic                  o_ram_we,
   output logic [STRB_W-1:0]     o_ram_be,
   output logic                  o_ram_re,
   output logic [IDX_W-1:0]      o_ram_idx,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   input  logic [DATA_WIDTH-1:0] i_ram_rdata,
   input  logic                  i_calc_end,
   output logic                  o_data_loaded,
   output logic                  o_busy
);
   localparam int SH = $clog2(STRB_W);
   localparam int FD = RAM_RD_LAT + 1;
   localparam int CW = $clog2(FD + 1);
   localparam int PW = $clog2(FD);
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_DATA, RD_DRAIN} state_t;
   state_t state, next;

   logic                  calc_done, fixed_q, err_q, loaded_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [7:0]            len_q, cnt_q;
   logic [IDX_W-1:0]      idx_q, aw_start, ar_start, issue_idx, step;
   logic [1:0]            bresp_q;
   logic [RAM_RD_LAT-1:0] pipe_v, pipe_last;
   logic [CW-1:0]         out_cnt, fcnt;
   logic [PW-1:0]         wp, rp;
   logic [DATA_WIDTH-1:0] fifo_data [FD];
   logic                  fifo_last [FD];
   logic aw_fire, ar_fire, w_fire, w_exit, r_fire, push, credit;
   logic rd_issue, issue_last, issue_err, aw_bad, ar_bad;

   // Out-of-range means the final beat index would fall outside the RAM.
   function automatic logic burst_bad(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] last_idx;
      last_idx = 32'(addr >> SH) + 32'(len);
      return (size != 3'(SH)) || burst[1] || (last_idx >= 32'(DEPTH));
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
   endfunction

   assign aw_start = IDX_W'(i_awaddr >> SH);
   assign ar_start = IDX_W'(i_araddr >> SH);
   assign aw_bad   = burst_bad(i_awaddr, i_awlen, i_awsize, i_awburst);
   assign ar_bad   = burst_bad(i_araddr, i_arlen, i_arsize, i_arburst);
   assign step     = IDX_W'(!fixed_q);

   assign aw_fire = (state == IDLE) && i_awvalid;
   assign ar_fire = (state == IDLE) && !i_awvalid && calc_done && i_arvalid;
   assign w_fire  = (state == WR_DATA) && i_wvalid;
   assign w_exit  = w_fire && (i_wlast || (cnt_q == len_q));
   assign r_fire  = o_rvalid && i_rready;
   assign push    = pipe_v[RAM_RD_LAT-1];

   // Counting the beat popped this cycle as free keeps reads flowing at one beat per cycle.
   assign credit     = (int'(out_cnt) + int'(fcnt) - int'(r_fire)) < FD;
   assign rd_issue   = ar_fire || ((state == RD_DATA) && credit);
   assign issue_last = ar_fire ? (i_arlen == 8'd0) : (cnt_q == len_q);
   assign issue_idx  = ar_fire ? ar_start : idx_q;
   assign issue_err  = ar_fire ? ar_bad : err_q;

   assign o_awready   = (state == IDLE);
   assign o_arready   = (state == IDLE) && calc_done && !i_awvalid;
   assign o_wready    = (state == WR_DATA);
   assign o_bvalid    = (state == WR_RESP);
   assign o_bid       = id_q;
   assign o_bresp     = bresp_q;
   assign o_ram_we    = w_fire && !err_q;
   assign o_ram_be    = o_ram_we ? i_wstrb : '0;
   assign o_ram_wdata = o_ram_we ? i_wdata : '0;
   assign o_ram_re    = rd_issue && !issue_err;
   assign o_ram_idx   = o_ram_we ? idx_q : (o_ram_re ? issue_idx : '0);
   assign o_rvalid    = (fcnt != '0);
   assign o_rdata     = o_rvalid ? fifo_data[rp] : '0;
   assign o_rlast     = o_rvalid && fifo_last[rp];
   assign o_rid       = id_q;
   assign o_rresp     = err_q ? SLVERR : OKAY;
   assign o_data_loaded = loaded_q;
   assign o_busy      = (state != IDLE);

   always_comb begin
      next = state;
      case (state)
         IDLE:     if (aw_fire) next = WR_DATA;
                   else if (ar_fire) next = (i_arlen == 8'd0) ? RD_DRAIN : RD_DATA;
         WR_DATA:  if (w_exit) next = WR_RESP;
         WR_RESP:  if (i_bready) next = IDLE;
         RD_DATA:  if (rd_issue && issue_last) next = RD_DRAIN;
         RD_DRAIN: if (r_fire && o_rlast) next = IDLE;
         default:  next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state     <= IDLE;
         calc_done <= 1'b0;
         id_q      <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         fixed_q   <= 1'b0;
         err_q     <= 1'b0;
         bresp_q   <= OKAY;
         loaded_q  <= 1'b0;
         pipe_v    <= '0;
         pipe_last <= '0;
         out_cnt   <= '0;
         fcnt      <= '0;
         wp        <= '0;
         rp        <= '0;
      end else begin
         state <= next;
         if (aw_fire) calc_done <= 1'b0;
         else if (i_calc_end) calc_done <= 1'b1;
         loaded_q <= (state == WR_RESP) && i_bready && (bresp_q == OKAY);
         if (aw_fire) begin
            id_q    <= i_awid;
            len_q   <= i_awlen;
            cnt_q   <= 8'd0;
            idx_q   <= aw_start;
            fixed_q <= (i_awburst == 2'b00);
            err_q   <= aw_bad;
         end else if (ar_fire) begin
            id_q    <= i_arid;
            len_q   <= i_arlen;
            cnt_q   <= 8'd1;
            idx_q   <= ar_start + IDX_W'(i_arburst != 2'b00);
            fixed_q <= (i_arburst == 2'b00);
            err_q   <= ar_bad;
         end else if (w_fire) begin
            cnt_q <= cnt_q + 8'd1;
            idx_q <= idx_q + step;
            if (w_exit)
               bresp_q <= (err_q || (i_wlast != (cnt_q == len_q))) ? SLVERR : OKAY;
         end else if ((state == RD_DATA) && rd_issue) begin
            cnt_q <= cnt_q + 8'd1;
            idx_q <= idx_q + step;
         end
         pipe_v[0]    <= rd_issue;
         pipe_last[0] <= issue_last;
         for (int i = 1; i < RAM_RD_LAT; i++) begin
            pipe_v[i]    <= pipe_v[i-1];
            pipe_last[i] <= pipe_last[i-1];
         end
         out_cnt <= out_cnt + CW'(rd_issue) - CW'(push);
         fcnt    <= fcnt + CW'(push) - CW'(r_fire);
         if (push) wp <= ptr_inc(wp);
         if (r_fire) rp <= ptr_inc(rp);
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_data[wp] <= err_q ? '0 : i_ram_rdata;
         fifo_last[wp] <= pipe_last[RAM_RD_LAT-1];
      end
   end
endmodule

// File: tb/tb_axi_sample_bridge.sv
// tb/tb_axi_sample_bridge.sv - scoreboard bench for axi_sample_bridge with a RAM model.
module tb_axi_sample_bridge;
   localparam int DW = 32, AW = 12, DEPTH = 1024, IW = 2, LAT = 1;

   logic clk = 1'b0, rstn = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] awaddr, araddr;
   logic [7:0] awlen, arlen;
   logic [2:0] awsize, arsize;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic [IW-1:0] awid, arid, bid, rid;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, arready;
   logic rlast, rvalid, rready, ram_we, ram_re, calc_end, data_loaded, busy;
   logic [DW-1:0] wdata, rdata, ram_wdata, ram_rdata;
   logic [3:0] wstrb, ram_be;
   logic [9:0] ram_idx;

   axi_sample_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .ID_WIDTH(IW), .RAM_RD_LAT(LAT)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst), .i_awid(awid),
      .i_awvalid(awvalid), .o_awready(awready),
      .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
      .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
      .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst), .i_arid(arid),
      .i_arvalid(arvalid), .o_arready(arready),
      .o_rdata(rdata), .o_rid(rid), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready),
      .o_ram_we(ram_we), .o_ram_be(ram_be), .o_ram_re(ram_re), .o_ram_idx(ram_idx), .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata), .i_calc_end(calc_end), .o_data_loaded(data_loaded), .o_busy(busy)
   );

   typedef struct packed { logic [9:0] idx; logic [3:0] be; logic [31:0] data; } wr_t;
   typedef struct packed { logic [31:0] data; logic last; logic [1:0] resp; logic [1:0] id; } rd_t;

   int checks = 0, failures = 0;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] gold [DEPTH];
   wr_t wq[$];
   rd_t rq[$];
   wr_t mon_w;
   rd_t mon_r;
   logic no_re = 1'b0, stall_prev = 1'b0, prev_last;
   logic [DW-1:0] prev_data;

   // RAM model: one-cycle read latency, byte-enabled writes.
   always @(posedge clk) begin
      if (ram_we)
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem[ram_idx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      if (ram_re) ram_rdata <= mem[ram_idx];
   end

   always @(negedge clk) begin
      if (rstn) begin
         if (ram_we) begin
            checks++;
            if (wq.size() == 0) begin
               failures++; $display("FAIL ram_we_unexpected idx=%0d data=%h", ram_idx, ram_wdata);
            end else begin
               mon_w = wq.pop_front();
               if ({ram_idx, ram_be, ram_wdata} !== mon_w) begin
                  failures++; $display("FAIL ram_write got=%h exp=%h", {ram_idx, ram_be, ram_wdata}, mon_w);
               end
            end
         end
         if (stall_prev) begin
            checks++;
            if (!rvalid || rdata !== prev_data || rlast !== prev_last) begin
               failures++; $display("FAIL r_stable got=%b/%h/%b exp=1/%h/%b", rvalid, rdata, rlast, prev_data, prev_last);
            end
         end
         stall_prev = rvalid && !rready;
         prev_data = rdata;
         prev_last = rlast;
         if (rvalid && rready) begin
            checks++;
            if (rq.size() == 0) begin
               failures++; $display("FAIL r_unexpected data=%h", rdata);
            end else begin
               mon_r = rq.pop_front();
               if ({rdata, rlast, rresp, rid} !== mon_r) begin
                  failures++; $display("FAIL r_beat got=%h exp=%h", {rdata, rlast, rresp, rid}, mon_r);
               end
            end
         end
         if (no_re) begin
            checks++;
            if (ram_re !== 1'b0) begin failures++; $display("FAIL err_ram_re got=%b exp=0", ram_re); end
         end
      end else stall_prev = 1'b0;
   end

   task automatic do_aw(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [1:0] id);
      int n;
      awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awid = id; awvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!awready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (!awready) begin failures++; $display("FAIL aw_handshake got=0 exp=1"); end
      @(posedge clk); #1 awvalid = 1'b0;
   endtask

   task automatic do_wdata(input logic [11:0] addr, input logic [1:0] burst, input int nbeats, input int last_beat, input logic exp_we);
      int n;
      logic [9:0] idx;
      for (int i = 0; i < nbeats; i++) begin
         wdata = $urandom; wstrb = 4'hF; wlast = (i == last_beat); wvalid = 1'b1;
         idx = 10'(int'(addr[11:2]) + ((burst == 2'b01) ? i : 0));
         if (exp_we) begin wq.push_back(wr_t'({idx, wstrb, wdata})); gold[idx] = wdata; end
         n = 0;
         @(negedge clk);
         while (!wready && n < 50) begin @(negedge clk); n++; end
         checks++;
         if (!wready) begin failures++; $display("FAIL w_handshake beat=%0d got=0 exp=1", i); end
         @(posedge clk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic do_b(input logic [1:0] exp_resp, input logic [1:0] id);
      int n;
      bready = 1'b1; n = 0;
      @(negedge clk);
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (bvalid !== 1'b1 || bresp !== exp_resp || bid !== id) begin
         failures++; $display("FAIL b_resp got=%b/%h/%h exp=1/%h/%h", bvalid, bresp, bid, exp_resp, id);
      end
      @(posedge clk); #1 bready = 1'b0;
      @(negedge clk);
      checks++;
      if (data_loaded !== (exp_resp == 2'b00)) begin
         failures++; $display("FAIL data_loaded got=%b exp=%b", data_loaded, exp_resp == 2'b00);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (data_loaded !== 1'b0 || wq.size() != 0) begin
         failures++; $display("FAIL loaded_pulse_end got=%b/%0d exp=0/0", data_loaded, wq.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [1:0] id,
                          input logic exp_err, input logic toggle, input logic chk_lat);
      rd_t e;
      logic [9:0] idx;
      int n, lat;
      for (int i = 0; i <= int'(len); i++) begin
         idx = 10'(int'(addr[11:2]) + ((burst == 2'b01) ? i : 0));
         e.data = exp_err ? '0 : gold[idx];
         e.last = (i == int'(len));
         e.resp = exp_err ? 2'b10 : 2'b00;
         e.id = id;
         rq.push_back(e);
      end
      no_re = exp_err; rready = 1'b1;
      araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arid = id; arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!arready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (!arready) begin failures++; $display("FAIL ar_handshake got=0 exp=1"); end
      @(posedge clk); #1 arvalid = 1'b0;
      if (toggle) rready = ~rready;
      n = 0; lat = -1;
      while (rq.size() != 0 && n < 100) begin
         @(negedge clk); n++;
         if (lat < 0 && rvalid) lat = n;
         @(posedge clk); #1;
         if (toggle) rready = ~rready;
      end
      checks++;
      if (rq.size() != 0 || busy !== 1'b0) begin
         failures++; $display("FAIL rd_complete left=%0d busy=%b exp=0/0", rq.size(), busy);
      end
      if (chk_lat) begin
         checks++;
         if (lat != LAT + 1) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT + 1); end
      end
      rq.delete();
      no_re = 1'b0; rready = 1'b1;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bvalid, rvalid, wready, arready, ram_we, ram_re, data_loaded, busy} !== 8'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=00000000", {bvalid, rvalid, wready, arready, ram_we, ram_re, data_loaded, busy});
      end
      checks++;
      if ({bresp, rresp, bid, rid, ram_idx, rdata, ram_wdata} !== '0) begin
         failures++; $display("FAIL reset_data got=%h exp=0", {bresp, rresp, bid, rid, ram_idx, rdata, ram_wdata});
      end
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (awready !== 1'b1 || arready !== 1'b0) begin
         failures++; $display("FAIL idle_ready got=%b%b exp=10", awready, arready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_incr;
      do_aw(12'h000, 8'd7, 2'b01, 2'd1);
      do_wdata(12'h000, 2'b01, 8, 7, 1'b1);
      do_b(2'b00, 2'd1);
   endtask

   task automatic test_read_gating;
      araddr = 12'h010; arlen = 8'd3; arburst = 2'b01; arsize = 3'd2; arid = 2'd2; arvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (arready !== 1'b0) begin failures++; $display("FAIL ar_gated got=%b exp=0", arready); end
      end
      @(posedge clk); #1 arvalid = 1'b0; calc_end = 1'b1;
      @(posedge clk); #1 calc_end = 1'b0;
      do_read(12'h010, 8'd3, 2'b01, 2'd2, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_read_backpressure;
      do_read(12'h010, 8'd3, 2'b01, 2'd2, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_read_errors;
      do_read(12'h000, 8'd3, 2'b10, 2'd1, 1'b1, 1'b0, 1'b0);
      do_read(12'hFF8, 8'd3, 2'b01, 2'd3, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_write_early_wlast;
      do_aw(12'h100, 8'd3, 2'b01, 2'd0);
      do_wdata(12'h100, 2'b01, 2, 1, 1'b1);
      do_b(2'b10, 2'd0);
   endtask

   task automatic test_fixed_burst;
      do_aw(12'h040, 8'd2, 2'b00, 2'd3);
      do_wdata(12'h040, 2'b00, 3, 2, 1'b1);
      do_b(2'b00, 2'd3);
   endtask

   task automatic test_aw_ar_same_cycle;
      calc_end = 1'b1;
      @(posedge clk); #1 calc_end = 1'b0;
      araddr = 12'h020; arlen = 8'd1; arburst = 2'b01; arsize = 3'd2; arid = 2'd1; arvalid = 1'b1;
      awaddr = 12'h020; awlen = 8'd1; awburst = 2'b01; awsize = 3'd2; awid = 2'd2; awvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (awready !== 1'b1 || arready !== 1'b0) begin
         failures++; $display("FAIL aw_priority got=%b%b exp=10", awready, arready);
      end
      @(posedge clk); #1 awvalid = 1'b0;
      do_wdata(12'h020, 2'b01, 2, 1, 1'b1);
      do_b(2'b00, 2'd2);
      @(negedge clk);
      checks++;
      if (arready !== 1'b0) begin failures++; $display("FAIL ar_after_write got=%b exp=0", arready); end
      @(posedge clk); #1 arvalid = 1'b0; calc_end = 1'b1;
      @(posedge clk); #1 calc_end = 1'b0;
      do_read(12'h020, 8'd1, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_burst;
      do_aw(12'h080, 8'd7, 2'b01, 2'd2);
      do_wdata(12'h080, 2'b01, 2, -1, 1'b1);
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, bvalid, wready, ram_we} !== 4'b0) begin
         failures++; $display("FAIL reset_abort got=%b exp=0000", {busy, bvalid, wready, ram_we});
      end
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (awready !== 1'b1 || arready !== 1'b0 || wq.size() != 0) begin
         failures++; $display("FAIL reset_recover got=%b%b/%0d exp=10/0", awready, arready, wq.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awid = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arlen = '0; arsize = '0; arburst = '0; arid = '0; arvalid = 1'b0;
      rready = 1'b1; calc_end = 1'b0; ram_rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; gold[i] = '0; end
      test_reset;
      test_write_incr;
      test_read_gating;
      test_read_backpressure;
      test_read_errors;
      test_write_early_wlast;
      test_fixed_burst;
      test_aw_ar_same_cycle;
      test_reset_mid_burst;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
